ex_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and the funct3 that the ID-EX segment register delivers, and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While it works it raises `busy`, and the hazard unit uses that signal to hold the IF/ID/EX segment registers (`en`=0). The result is registered and handed to the EX-MEM path with a one-cycle `done` pulse.

---
 rtl/ex_muldiv_unit.sv | 186 ++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: multiply ops use a single-cycle 32x32 product and skip CALC.
module ex_muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [2:0]  op_q;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opnd_b;
    logic        neg_a;
    logic        neg_b;
    logic [4:0]  cnt;

    // Operand decode for the load edge
    logic        is_div;
    logic        signed_a;
    logic        signed_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic        fast_path;
    logic        load;

    always_comb begin
        is_div   = op[2];
        signed_a = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        signed_b = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg    = signed_a & a[31];
        b_neg    = signed_b & b[31];
        mag_a    = a_neg ? (~a + 32'd1) : a;
        mag_b    = b_neg ? (~b + 32'd1) : b;
        div_zero = is_div && (b == 32'd0);
        div_ovf  = is_div && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        special  = div_zero || div_ovf;
        load     = start && ((state == S_IDLE) || (state == S_DONE));
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] prod_fast;
    always_comb begin
        fast_path = !is_div;
        prod_fast = {32'd0, mag_a} * {32'd0, mag_b};
    end
`else
    always_comb begin
        fast_path = 1'b0;
    end
`endif

    // One multiply iteration: conditional add into the high half, then shift the pair right
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_nx;
    logic [31:0] mul_lo_nx;
    // One divide iteration: shift in the next dividend bit, subtract divisor if it fits
    logic [32:0] rem_sh;
    logic        rem_ge;
    logic [31:0] rem_diff;
    logic [31:0] div_hi_nx;
    logic [31:0] div_lo_nx;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
        mul_hi_nx = mul_sum[32:1];
        mul_lo_nx = {mul_sum[0], acc_lo[31:1]};
        rem_sh    = {acc_hi, acc_lo[31]};
        rem_ge    = rem_sh >= {1'b0, opnd_b};
        rem_diff  = rem_sh[31:0] - opnd_b;
        div_hi_nx = rem_ge ? rem_diff : rem_sh[31:0];
        div_lo_nx = {acc_lo[30:0], rem_ge};
    end

    // Sign correction and result selection
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_result;

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
        quo_fix  = (neg_a ^ neg_b) ? (~acc_lo + 32'd1) : acc_lo;
        rem_fix  = neg_a ? (~acc_hi + 32'd1) : acc_hi;
        case (op_q)
            3'b000:                 fix_result = prod_fix[31:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
            3'b100, 3'b101:         fix_result = quo_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state_nx = (special || fast_path) ? S_FIX : S_CALC;
                S_CALC: if (cnt == 5'd31) state_nx = S_FIX;
                S_FIX:  state_nx = S_DONE;
                S_DONE: state_nx = start ? ((special || fast_path) ? S_FIX : S_CALC) : S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= 3'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            opnd_b <= 32'd0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else if (!flush) begin
            if (load) begin
                op_q   <= op;
                cnt    <= 5'd0;
                opnd_b <= mag_b;
                if (div_zero) begin
                    // Raw dividend as remainder, all-ones quotient, no sign fixing
                    acc_hi <= a;
                    acc_lo <= 32'hFFFF_FFFF;
                    neg_a  <= 1'b0;
                    neg_b  <= 1'b0;
                end else if (div_ovf) begin
                    acc_hi <= 32'd0;
                    acc_lo <= 32'h8000_0000;
                    neg_a  <= 1'b0;
                    neg_b  <= 1'b0;
                end else begin
`ifdef MULDIV_FAST_MUL_EN
                    acc_hi <= fast_path ? prod_fast[63:32] : 32'd0;
                    acc_lo <= fast_path ? prod_fast[31:0] : mag_a;
`else
                    acc_hi <= 32'd0;
                    acc_lo <= mag_a;
`endif
                    neg_a  <= a_neg;
                    neg_b  <= b_neg;
                end
            end else if (state == S_CALC) begin
                cnt    <= cnt + 5'd1;
                acc_hi <= op_q[2] ? div_hi_nx : mul_hi_nx;
                acc_lo <= op_q[2] ? div_lo_nx : mul_lo_nx;
            end else if (state == S_FIX) begin
                result <= fix_result;
            end
        end
    end

    assign busy      = (state == S_CALC) || (state == S_FIX);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for all eight ops plus control sequences
// (flush, ignored start, back-to-back start, mid-operation reset).
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle start_lat after the load edge; returns the done cycle
    task automatic wait_done(input int start_lat, output int lat, output bit busy_gap);
        lat      = start_lat;
        busy_gap = 1'b0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_gap = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string name, input int lat, input bit gap, input int exp_lat);
        logic [31:0] e;
        check({name, " latency"}, lat, exp_lat);
        check({name, " busy gap"}, {31'd0, gap}, 32'd0);
        check({name, " busy with done"}, {31'd0, busy}, 32'd0);
        e = exp_q.pop_front();
        check({name, " result"}, result, e);
        last_res = e;
    endtask

    task automatic run_vec(input string name, input logic [2:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] r, input int exp_lat);
        int lat;
        bit gap;
        exp_q.push_back(r);
        issue(o, x, y);
        wait_done(1, lat, gap);
        finish_op(name, lat, gap, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        bit gap;
        int el;

        tbl[0]  = '{"mul 7*-3",       3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        tbl[1]  = '{"mulh min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        tbl[2]  = '{"mulhsu min*min", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34};
        tbl[3]  = '{"mulhu min*min",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        tbl[4]  = '{"div -7/2",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        tbl[5]  = '{"rem -7/2",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        tbl[6]  = '{"divu -7/2",      3'b101, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 34};
        tbl[7]  = '{"remu -7/2",      3'b111, 32'hFFFF_FFF9, 32'd2,         32'd1,         34};
        tbl[8]  = '{"div by zero",    3'b100, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 2};
        tbl[9]  = '{"rem by zero",    3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 2};
        tbl[10] = '{"div overflow",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[11] = '{"rem overflow",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2};
        tbl[12] = '{"mulh -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         34};
        tbl[13] = '{"mulhu -1*-1",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        tbl[14] = '{"mul 2^16*2^16",  3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0,         34};
        tbl[15] = '{"mulhu 2^16^2",   3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1,         34};
        tbl[16] = '{"div 7/-2",       3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        tbl[17] = '{"rem 7/-2",       3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         34};
        tbl[18] = '{"divu by zero",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        tbl[19] = '{"remu by zero",   3'b111, 32'd5,         32'd0,         32'd5,         2};
        tbl[20] = '{"divu min/-1",    3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};
        tbl[21] = '{"divu 100/7",     3'b101, 32'd100,       32'd7,         32'd14,        34};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            el = (FAST && !tbl[i].op[2]) ? 2 : tbl[i].lat;
            run_vec(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, el);
        end

        // flush and start together in IDLE: flush wins
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b100; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush beats start busy", {31'd0, busy}, 32'd0);

        // flush at cycle 10 of a divide
        issue(3'b100, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        check("flush done", {31'd0, done}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("flush no done", seen, 32'd0);
        check("flush result held", result, last_res);

        // start while busy is ignored
        exp_q.push_back(32'd14);
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, gap);
        finish_op("ignored start", lat, gap, 34);

        // back-to-back: start during the DONE cycle
        exp_q.push_back(32'd2);
        start = 1'b1; op = 3'b111; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, lat, gap);
        finish_op("back to back", lat, gap, 34);

        // reset in the middle of CALC
        issue(3'b100, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        check("mid reset result", result, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("mid reset no done", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
